// File: rtl/aes_pkg.sv
// Shared AES byte/block geometry and the two-state unpacker FSM type.
package aes_pkg;

    localparam int AES_BLOCK_W   = 128;
    localparam int AES_BYTE_W    = 8;
    localparam int AES_NUM_BYTES = 16;

    // Index of the final byte of a block (B15).
    localparam logic [3:0] LAST_IDX = 4'(AES_NUM_BYTES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

endpackage

// File: rtl/byte_unpacker.sv
// byte_unpacker: serialises a 128-bit AES block into 16 bytes, B0 (MSB) first,
// with valid/ready handshakes on both sides.
// Optional feature macro: BYTE_UNPACKER_PREFETCH_EN -- accept the next block
// while B15 is being handed off, giving back-to-back blocks with no bubble.
module byte_unpacker
    import aes_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [AES_BLOCK_W-1:0] in_block,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [AES_BYTE_W-1:0]  out_byte,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last
);

    state_e                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [AES_BLOCK_W-1:0] sreg_q, sreg_d;
    logic                   in_hs, out_hs, at_last;

    assign at_last   = (cnt_q == LAST_IDX);
    assign out_valid = (state_q == SEND);
    assign out_last  = out_valid && at_last;
    assign out_byte  = sreg_q[AES_BLOCK_W-1 -: AES_BYTE_W];

`ifdef BYTE_UNPACKER_PREFETCH_EN
    // The slot frees up exactly when B15 leaves, so a new block may land then.
    assign in_ready = (state_q == IDLE) || (out_valid && at_last && out_ready);
`else
    assign in_ready = (state_q == IDLE);
`endif

    assign in_hs  = in_valid && in_ready;
    assign out_hs = out_valid && out_ready;

    // Next-state: a load wins over the B15 hand-off; otherwise shift on each accepted byte.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sreg_d  = sreg_q;
        if (in_hs) begin
            state_d = SEND;
            cnt_d   = 4'd0;
            sreg_d  = in_block;
        end else if (out_hs) begin
            if (at_last) begin
                state_d = IDLE;
            end else begin
                cnt_d  = cnt_q + 4'd1;
                sreg_d = {sreg_q[AES_BLOCK_W-AES_BYTE_W-1:0], {AES_BYTE_W{1'b0}}};
            end
        end
    end

    // State, counter and shift register, all cleared by reset so out_byte reads 0x00.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            sreg_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sreg_q  <= sreg_d;
        end
    end

endmodule

// File: tb/tb_byte_unpacker.sv
// Self-checking bench for byte_unpacker: queue-based reference model plus
// directed scenarios (order, backpressure, busy ignore, reset, back-to-back)
// and a randomized phase. Honors BYTE_UNPACKER_PREFETCH_EN.
module tb_byte_unpacker;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] in_block;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   out_byte;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;

    int checks = 0;
    int errors = 0;

`ifdef BYTE_UNPACKER_PREFETCH_EN
    localparam bit PREF = 1'b1;
`else
    localparam bit PREF = 1'b0;
`endif

    localparam logic [127:0] K = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    always #5 clk = ~clk;

    byte_unpacker dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_block  (in_block),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_byte  (out_byte),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    // Reference model: the bytes still owed to the downstream, front = current.
    logic [7:0] mq[$];
    bit         chk_en = 1'b0;

    function automatic bit exp_in_ready();
        return (mq.size() == 0) || (PREF && mq.size() == 1 && out_ready);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit ihs;
        ihs = in_valid && exp_in_ready();
        if (!rst_n) begin
            mq.delete();
        end else begin
            if (mq.size() > 0 && out_ready) void'(mq.pop_front());
            if (ihs) for (int i = 0; i < 16; i++) mq.push_back(in_block[127-8*i -: 8]);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", {31'b0, in_ready}, {31'b0, exp_in_ready()});
            check("out_valid", {31'b0, out_valid}, {31'b0, mq.size() != 0});
            if (mq.size() != 0) begin
                check("out_byte", {24'b0, out_byte}, {24'b0, mq[0]});
                check("out_last", {31'b0, out_last}, {31'b0, mq.size() == 1});
            end
        end
    end

    // Capture every accepted output byte and the cycle it was accepted on.
    int         cyc = 0;
    logic [7:0] got[$];
    int         got_cyc[$];
    always @(posedge clk) begin
        cyc++;
        if (rst_n && out_valid && out_ready) begin
            got.push_back(out_byte);
            got_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_block(input logic [127:0] blk, output int hs_cyc);
        bit hs;
        bit done;
        done      = 1'b0;
        hs_cyc    = -1;
        in_block  = blk;
        in_valid  = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            hs = in_ready;
            tick();
            if (hs) begin
                done   = 1'b1;
                hs_cyc = cyc;
            end
        end
        in_valid = 1'b0;
        if (!done) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_bytes(input int n);
        for (int i = 0; i < 400; i++) begin
            if (got.size() >= n) return;
            tick();
        end
        check("byte_timeout", got.size(), n);
    endtask

    task automatic check_block(input string tag, input int off, input logic [127:0] blk);
        for (int i = 0; i < 16; i++) begin
            if (off + i < got.size())
                check(tag, {24'b0, got[off+i]}, {24'b0, blk[127-8*i -: 8]});
            else
                check({tag, "_missing"}, 32'd0, 32'd1);
        end
    endtask

    initial begin
        int         hc;
        int         nhs;
        bit         hs;
        logic [127:0] k2;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_block  = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_last", {31'b0, out_last}, 32'd0);
        check("rst_out_byte", {24'b0, out_byte}, 32'h00);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk_en = 1'b1;

        // Basic order with the known vector.
        got.delete(); got_cyc.delete();
        out_ready = 1'b1;
        send_block(K, hc);
        wait_bytes(16);
        check("basic_b0", {24'b0, got[0]}, 32'h69);
        check("basic_b1", {24'b0, got[1]}, 32'hc4);
        check("basic_b2", {24'b0, got[2]}, 32'he0);
        check("basic_b14", {24'b0, got[14]}, 32'hc5);
        check("basic_b15", {24'b0, got[15]}, 32'h5a);
        check("basic_first_cyc", got_cyc[0], hc + 1);
        check("basic_last_cyc", got_cyc[15], hc + 16);
        check_block("basic", 0, K);
        tick();

        // Backpressure: out_ready pattern 1,0,0 repeating.
        got.delete(); got_cyc.delete();
        send_block(K, hc);
        for (int i = 0; i < 200 && got.size() < 16; i++) begin
            out_ready = (i % 3 == 0);
            tick();
        end
        out_ready = 1'b1;
        check_block("bp", 0, K);
        tick();

        // Busy ignore: all-ones block offered while B4 is pending.
        got.delete(); got_cyc.delete();
        send_block(K, hc);
        wait_bytes(4);
        out_ready = 1'b0;
        in_block  = '1;
        in_valid  = 1'b1;
        tick(); tick(); tick();
        check("busy_in_ready", {31'b0, in_ready}, 32'd0);
        check("busy_byte4", {24'b0, out_byte}, 32'h6a);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_bytes(16);
        tick();
        check("busy_count", got.size(), 16);
        check_block("busy", 0, K);

        // Reset after byte 7 has been accepted.
        got.delete(); got_cyc.delete();
        send_block(K, hc);
        wait_bytes(8);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_out_byte", {24'b0, out_byte}, 32'h00);
        check("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("mid_rst_count", got.size(), 8);
        got.delete(); got_cyc.delete();
        send_block(K, hc);
        wait_bytes(16);
        check("restart_b0", {24'b0, got[0]}, 32'h69);
        check_block("restart", 0, K);
        tick();

        // Back-to-back blocks with in_valid held high.
        got.delete(); got_cyc.delete();
        k2        = {$urandom, $urandom, $urandom, $urandom};
        out_ready = 1'b1;
        in_block  = K;
        in_valid  = 1'b1;
        nhs       = 0;
        for (int i = 0; i < 100 && nhs < 2; i++) begin
            hs = in_ready;
            tick();
            if (hs) begin
                nhs++;
                in_block = k2;
            end
        end
        in_valid = 1'b0;
        check("b2b_handshakes", nhs, 2);
        wait_bytes(32);
        check_block("b2b_first", 0, K);
        check_block("b2b_second", 16, k2);
        if (got_cyc.size() >= 17)
            check("b2b_gap", got_cyc[16] - got_cyc[15], PREF ? 1 : 2);
        else
            check("b2b_gap_missing", got_cyc.size(), 17);

        // Randomized traffic with occasional resets; the model checks every cycle.
        for (int i = 0; i < 600; i++) begin
            rst_n     = ($urandom_range(0, 79) != 0);
            in_valid  = $urandom_range(0, 1);
            out_ready = ($urandom_range(0, 3) != 0);
            in_block  = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) tick();
        check("drain_idle", {31'b0, out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
